// File: rtl/seg7_capture.sv
// -----------------------------------------------------------------------------
// seg7_capture
//   Reads back a scanned, active-low 7-segment display bus. Both the shared
//   segment lines and the per-digit anode lines are synchronized into the clk
//   domain. A digit pattern is committed only after it has been seen unchanged
//   for STABLE_CYCLES consecutive synchronized samples. A committed pattern is
//   decoded back to a hex nibble and stored per digit position.
//
// Ports
//   clk      in   1          rising-edge clock
//   rst_n    in   1          asynchronous active-low reset
//   seg_n    in   7          segment lines, active-low, bit0=a .. bit6=g
//   an_n     in   NDIGITS    digit enables, active-low, bit i = digit i
//   clr      in   1          synchronous clear of captured state (top priority)
//   digits   out  4*NDIGITS  captured values, digit i at [4i+3:4i]
//   valid    out  NDIGITS    digit i holds a correctly decoded value
//   err      out  NDIGITS    last committed pattern on digit i was not a hex glyph
//   upd      out  1          one-cycle pulse per commit
//   upd_idx  out  IW         digit index of the current/last commit
// -----------------------------------------------------------------------------
module seg7_capture #(
    parameter  int NDIGITS       = 8,
    parameter  int STABLE_CYCLES = 4,
    localparam int IW            = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [6:0]             seg_n,
    input  logic [NDIGITS-1:0]     an_n,
    input  logic                   clr,
    output logic [4*NDIGITS-1:0]   digits,
    output logic [NDIGITS-1:0]     valid,
    output logic [NDIGITS-1:0]     err,
    output logic                   upd,
    output logic [IW-1:0]          upd_idx
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Returns {exactly_one_anode_low, index_of_that_anode}.
    function automatic logic [IW:0] onehot_idx(input logic [NDIGITS-1:0] an);
        int unsigned   zeros;
        logic [IW-1:0] idx;
        zeros = 32'd0;
        idx   = {IW{1'b0}};
        for (int i = 0; i < NDIGITS; i++) begin
            if (!an[i]) begin
                zeros = zeros + 32'd1;
                idx   = IW'(i);
            end
        end
        return {(zeros == 32'd1), idx};
    endfunction

    // Returns {is_hex_glyph, value}; pattern is active-high gfedcba.
    function automatic logic [4:0] glyph_decode(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    logic [6:0]           seg_m_r, s_seg_r;
    logic [NDIGITS-1:0]   an_m_r, s_an_r;
    state_t               state_r, state_nxt_s;
    logic [NDIGITS-1:0]   an_lat_r;
    logic [6:0]           seg_lat_r;
    logic [IW-1:0]        idx_r;
    logic [CW-1:0]        cnt_r;
    logic                 load_s, inc_s, commit_s, same_s, oh_s;
    logic [IW-1:0]        oh_idx_s;
    logic [4:0]           dec_s;
    logic [4*NDIGITS-1:0] digits_r;
    logic [NDIGITS-1:0]   valid_r, err_r;
    logic                 upd_r;
    logic [IW-1:0]        upd_idx_r;

    assign {oh_s, oh_idx_s} = onehot_idx(s_an_r);
    assign same_s           = (s_an_r == an_lat_r) && (s_seg_r == seg_lat_r);
    assign dec_s            = glyph_decode(~seg_lat_r);

    // Two-flop synchronizers; idle bus (all lines high) is the reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m_r <= {7{1'b1}};
            s_seg_r <= {7{1'b1}};
            an_m_r  <= {NDIGITS{1'b1}};
            s_an_r  <= {NDIGITS{1'b1}};
        end else begin
            seg_m_r <= seg_n;
            s_seg_r <= seg_m_r;
            an_m_r  <= an_n;
            s_an_r  <= an_m_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic plus latch/count strobes for the tracking datapath.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        inc_s       = 1'b0;
        if (clr) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (oh_s) begin
                        load_s      = 1'b1;
                        state_nxt_s = ST_TRACK;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_TRACK: begin
                    if (same_s) begin
                        inc_s = 1'b1;
                        // cnt_r is the count before this sample is added.
                        if (cnt_r >= CW'(STABLE_CYCLES - 1)) begin
                            state_nxt_s = ST_COMMIT;
                        end else begin
                            state_nxt_s = ST_TRACK;
                        end
                    end else if (oh_s) begin
                        load_s      = 1'b1;
                        state_nxt_s = ST_TRACK;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    state_nxt_s = ST_HOLD;
                end
                ST_HOLD: begin
                    if (same_s) begin
                        state_nxt_s = ST_HOLD;
                    end else if (oh_s) begin
                        load_s      = 1'b1;
                        state_nxt_s = ST_TRACK;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM output logic: a commit is suppressed when clr coincides with it.
    always_comb begin
        commit_s = 1'b0;
        if ((state_r == ST_COMMIT) && !clr) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Candidate latch and saturating stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_lat_r  <= {NDIGITS{1'b1}};
            seg_lat_r <= {7{1'b1}};
            idx_r     <= {IW{1'b0}};
            cnt_r     <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (load_s) begin
            an_lat_r  <= s_an_r;
            seg_lat_r <= s_seg_r;
            idx_r     <= oh_idx_s;
            cnt_r     <= CW'(1);
        end else if (inc_s && (cnt_r < CW'(STABLE_CYCLES))) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Captured-value registers; a commit only touches the committed digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_r  <= {(4*NDIGITS){1'b0}};
            valid_r   <= {NDIGITS{1'b0}};
            err_r     <= {NDIGITS{1'b0}};
            upd_r     <= 1'b0;
            upd_idx_r <= {IW{1'b0}};
        end else if (clr) begin
            digits_r  <= {(4*NDIGITS){1'b0}};
            valid_r   <= {NDIGITS{1'b0}};
            err_r     <= {NDIGITS{1'b0}};
            upd_r     <= 1'b0;
            upd_idx_r <= {IW{1'b0}};
        end else begin
            upd_r <= commit_s;
            if (commit_s) begin
                upd_idx_r <= idx_r;
                if (dec_s[4]) begin
                    digits_r[{idx_r, 2'b00} +: 4] <= dec_s[3:0];
                    valid_r[idx_r]                <= 1'b1;
                    err_r[idx_r]                  <= 1'b0;
                end else begin
                    valid_r[idx_r] <= 1'b0;
                    err_r[idx_r]   <= 1'b1;
                end
            end
        end
    end

    assign digits  = digits_r;
    assign valid   = valid_r;
    assign err     = err_r;
    assign upd     = upd_r;
    assign upd_idx = upd_idx_r;

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [7:0]  an_n;
    logic        clr;
    logic [31:0] digits;
    logic [7:0]  valid;
    logic [7:0]  err;
    logic        upd;
    logic [2:0]  upd_idx;

    int vectors;
    int miscompares;
    int pulses;
    int edge_no;
    int first_edge;

    logic [6:0] glyph [16];

    seg7_capture #(.NDIGITS(8), .STABLE_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg_n   (seg_n),
        .an_n    (an_n),
        .clr     (clr),
        .digits  (digits),
        .valid   (valid),
        .err     (err),
        .upd     (upd),
        .upd_idx (upd_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold the bus for n edges, sampling upd on each following negedge.
    task automatic drive(input logic [7:0] an, input logic [6:0] seg, input int n);
        an_n  = an;
        seg_n = seg;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            edge_no++;
            @(negedge clk);
            if (upd === 1'b1) begin
                pulses++;
                if (first_edge < 0) first_edge = edge_no;
            end
        end
    endtask

    task automatic start_window();
        pulses     = 0;
        edge_no    = 0;
        first_edge = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr   = 1'b0;
        an_n  = 8'($urandom);
        seg_n = 7'($urandom);
        #1;
        vectors++;
        if ({digits, valid, err, upd, upd_idx} !== 52'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h required 0", {digits, valid, err, upd, upd_idx});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            an_n  = 8'($urandom);
            seg_n = 7'($urandom);
        end
        @(negedge clk);
        vectors++;
        if ({digits, valid, err, upd, upd_idx} !== 52'd0) begin
            miscompares++;
            $display("FAIL reset_held: got %h required 0", {digits, valid, err, upd, upd_idx});
        end
        an_n  = 8'hFF;
        seg_n = 7'h7F;
        rst_n = 1'b1;
        start_window();
        drive(8'hFF, 7'h7F, 50);
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL idle_no_upd: got %0d pulses required 0", pulses);
        end
    endtask

    task automatic test_single_commit();
        start_window();
        drive(8'hFE, ~7'h5B, 20);
        vectors++;
        if (first_edge !== 7) begin
            miscompares++;
            $display("FAIL latency: upd rose on edge %0d required 7", first_edge);
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL single_pulse: got %0d pulses required 1", pulses);
        end
        vectors++;
        if (upd_idx !== 3'd0 || digits[3:0] !== 4'h2) begin
            miscompares++;
            $display("FAIL digit0_value: got idx %0d val %h required idx 0 val 2", upd_idx, digits[3:0]);
        end
        vectors++;
        if (valid !== 8'h01 || err !== 8'h00) begin
            miscompares++;
            $display("FAIL digit0_flags: got valid %h err %h required 01 00", valid, err);
        end
    endtask

    task automatic test_scan();
        start_window();
        for (int d = 0; d < 8; d++) begin
            drive(~(8'h01 << d), ~glyph[d], 6);
        end
        drive(8'hFF, 7'h7F, 6);
        vectors++;
        if (pulses !== 8) begin
            miscompares++;
            $display("FAIL scan_pulses: got %0d required 8", pulses);
        end
        vectors++;
        if (digits !== 32'h76543210) begin
            miscompares++;
            $display("FAIL scan_digits: got %h required 76543210", digits);
        end
        vectors++;
        if (valid !== 8'hFF || err !== 8'h00 || upd_idx !== 3'd7) begin
            miscompares++;
            $display("FAIL scan_flags: got valid %h err %h idx %0d required FF 00 7", valid, err, upd_idx);
        end
    endtask

    task automatic test_stability();
        start_window();
        drive(8'hFB, ~glyph[10], 3);
        drive(8'hFF, 7'h7F, 10);
        vectors++;
        if (pulses !== 0 || digits !== 32'h76543210) begin
            miscompares++;
            $display("FAIL short_hold: got %0d pulses digits %h required 0 76543210", pulses, digits);
        end
        start_window();
        drive(8'hFB, ~glyph[10], 4);
        drive(8'hFF, 7'h7F, 10);
        vectors++;
        if (pulses !== 1 || digits !== 32'h76543A10) begin
            miscompares++;
            $display("FAIL min_hold: got %0d pulses digits %h required 1 76543a10", pulses, digits);
        end
    endtask

    task automatic test_ghost_and_blank();
        start_window();
        drive(8'hFC, ~glyph[8], 20);
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL two_anodes: got %0d pulses required 0", pulses);
        end
        start_window();
        drive(8'hF7, ~7'h00, 12);
        vectors++;
        if (pulses !== 1 || upd_idx !== 3'd3) begin
            miscompares++;
            $display("FAIL blank_commit: got %0d pulses idx %0d required 1 3", pulses, upd_idx);
        end
        vectors++;
        if (err !== 8'h08 || valid !== 8'hF7 || digits !== 32'h76543A10) begin
            miscompares++;
            $display("FAIL blank_flags: got err %h valid %h digits %h required 08 f7 76543a10", err, valid, digits);
        end
    endtask

    task automatic test_clr_commit();
        start_window();
        drive(8'hFB, ~glyph[5], 6);
        clr = 1'b1;
        drive(8'hFF, 7'h7F, 1);
        clr = 1'b0;
        drive(8'hFF, 7'h7F, 10);
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL clr_commit_upd: got %0d pulses required 0", pulses);
        end
        vectors++;
        if ({digits, valid, err, upd_idx} !== 51'd0) begin
            miscompares++;
            $display("FAIL clr_outputs: got %h required 0", {digits, valid, err, upd_idx});
        end
    endtask

    task automatic test_async_reset();
        start_window();
        drive(8'hFD, ~glyph[9], 12);
        vectors++;
        if (digits !== 32'h00000090 || valid !== 8'h02) begin
            miscompares++;
            $display("FAIL pre_reset_commit: got digits %h valid %h required 00000090 02", digits, valid);
        end
        drive(8'hF7, ~glyph[4], 4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({digits, valid, err, upd, upd_idx} !== 52'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h required 0", {digits, valid, err, upd, upd_idx});
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_window();
        drive(8'hEF, ~glyph[15], 12);
        vectors++;
        if (pulses !== 1 || digits !== 32'h000F0000 || valid !== 8'h10 || upd_idx !== 3'd4) begin
            miscompares++;
            $display("FAIL post_reset_commit: got %0d pulses digits %h valid %h idx %0d required 1 000f0000 10 4",
                     pulses, digits, valid, upd_idx);
        end
    endtask

    initial begin
        glyph[0]  = 7'h3F; glyph[1]  = 7'h06; glyph[2]  = 7'h5B; glyph[3]  = 7'h4F;
        glyph[4]  = 7'h66; glyph[5]  = 7'h6D; glyph[6]  = 7'h7D; glyph[7]  = 7'h07;
        glyph[8]  = 7'h7F; glyph[9]  = 7'h6F; glyph[10] = 7'h77; glyph[11] = 7'h7C;
        glyph[12] = 7'h39; glyph[13] = 7'h5E; glyph[14] = 7'h79; glyph[15] = 7'h71;
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_commit();
        test_scan();
        test_stability();
        test_ghost_and_blank();
        test_clr_commit();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
